// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: picks the next mole from a free-running LFSR, lights it
// for an adaptive window and flags unhit expiries with a one-cycle led_toggle.
module mole_spawner #(
  parameter int          N_MOLES     = 10,
  parameter int          WINDOW_INIT = 50_000_000,
  parameter int          WINDOW_MIN  = 10_000_000,
  parameter int          WINDOW_STEP = 2_500_000,
  parameter int          GAP_CYCLES  = 12_500_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         WIN_W       = $clog2(WINDOW_INIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               hit_pulse,
  input  logic               miss_pulse,
  output logic [N_MOLES-1:0] active_onehot,
  output logic               led_toggle,
  output logic [WIN_W-1:0]   window_cycles,
  output logic [7:0]         round_cnt
);

  localparam int IW = $clog2(N_MOLES);
  localparam int GW = $clog2(GAP_CYCLES);

  localparam logic [IW:0]         N_W      = (IW+1)'(N_MOLES);
  localparam logic [IW:0]         LAST_W   = (IW+1)'(N_MOLES - 1);
  localparam logic [IW:0]         ONE_I    = (IW+1)'(1);
  localparam logic [N_MOLES-1:0]  ONE_HOT  = N_MOLES'(1);
  localparam logic [GW-1:0]       GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]       GAP_ONE  = GW'(1);
  localparam logic [WIN_W:0]      STEP_W   = (WIN_W+1)'(WINDOW_STEP);
  localparam logic [WIN_W:0]      MIN_W    = (WIN_W+1)'(WINDOW_MIN);
  localparam logic [WIN_W:0]      INIT_W   = (WIN_W+1)'(WINDOW_INIT);
  localparam logic [WIN_W-1:0]    WIN_ONE  = WIN_W'(1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t              state_reg, state_next;
  logic [GW-1:0]       gap_cnt_reg, gap_cnt_next;
  logic [WIN_W-1:0]    win_cnt_reg, win_cnt_next;
  logic [15:0]         lfsr_reg, lfsr_next;
  logic [IW-1:0]       prev_idx_reg, prev_idx_next;
  logic [N_MOLES-1:0]  active_next;
  logic                led_toggle_next;
  logic [WIN_W-1:0]    window_next;
  logic [7:0]          round_next;

  logic [IW:0]         raw_idx, fold_idx, pick_idx;
  logic [WIN_W:0]      win_dec, win_inc;
  logic [WIN_W-1:0]    win_after_hit, win_after_miss;

  // Fold the raw LFSR bits into range, then step past the previous mole.
  always_comb begin
    raw_idx  = {1'b0, lfsr_reg[IW-1:0]};
    fold_idx = (raw_idx >= N_W) ? raw_idx - N_W : raw_idx;
    pick_idx = fold_idx;
    if (fold_idx == {1'b0, prev_idx_reg}) begin
      pick_idx = (fold_idx == LAST_W) ? '0 : fold_idx + ONE_I;
    end
  end

  // One guard bit so both directions saturate instead of wrapping.
  always_comb begin
    win_dec        = {1'b0, window_cycles} - STEP_W;
    win_inc        = {1'b0, window_cycles} + STEP_W;
    win_after_hit  = (win_dec[WIN_W] || win_dec < MIN_W) ? MIN_W[WIN_W-1:0] : win_dec[WIN_W-1:0];
    win_after_miss = (win_inc > INIT_W) ? INIT_W[WIN_W-1:0] : win_inc[WIN_W-1:0];
  end

  always_comb begin
    state_next      = state_reg;
    gap_cnt_next    = gap_cnt_reg;
    win_cnt_next    = win_cnt_reg;
    prev_idx_next   = prev_idx_reg;
    active_next     = active_onehot;
    led_toggle_next = 1'b0;
    window_next     = window_cycles;
    round_next      = round_cnt;
    lfsr_next       = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    if (!enable) begin
      state_next   = IDLE;
      active_next  = '0;
      gap_cnt_next = '0;
      win_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next   = GAP;
          gap_cnt_next = GAP_LOAD;
        end
        GAP: begin
          if (gap_cnt_reg == '0) begin
            state_next    = SHOW;
            active_next   = ONE_HOT << pick_idx[IW-1:0];
            prev_idx_next = pick_idx[IW-1:0];
            win_cnt_next  = window_cycles - WIN_ONE;
            round_next    = round_cnt + 8'd1;
          end else begin
            gap_cnt_next = gap_cnt_reg - GAP_ONE;
          end
        end
        SHOW: begin
          if (hit_pulse || win_cnt_reg == '0) begin
            state_next   = GAP;
            active_next  = '0;
            gap_cnt_next = GAP_LOAD;
          end else begin
            win_cnt_next    = win_cnt_reg - WIN_ONE;
            led_toggle_next = (win_cnt_reg == WIN_ONE);
          end
        end
        default: begin
          state_next  = IDLE;
          active_next = '0;
        end
      endcase
    end

    if (state_reg != IDLE) begin
      if (hit_pulse) begin
        window_next = win_after_hit;
      end else if (miss_pulse) begin
        window_next = win_after_miss;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      gap_cnt_reg   <= '0;
      win_cnt_reg   <= '0;
      lfsr_reg      <= LFSR_SEED;
      prev_idx_reg  <= LAST_W[IW-1:0];
      active_onehot <= '0;
      led_toggle    <= 1'b0;
      window_cycles <= INIT_W[WIN_W-1:0];
      round_cnt     <= 8'd0;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      win_cnt_reg   <= win_cnt_next;
      lfsr_reg      <= lfsr_next;
      prev_idx_reg  <= prev_idx_next;
      active_onehot <= active_next;
      led_toggle    <= led_toggle_next;
      window_cycles <= window_next;
      round_cnt     <= round_next;
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: table of rounds driven with hit/miss timing, a scoreboard
// of expected window episodes and an LFSR reference for the chosen mole.
module tb_mole_spawner;

  localparam int          N    = 10;
  localparam int          WI   = 20;
  localparam int          WMIN = 8;
  localparam int          WST  = 4;
  localparam int          GAP  = 5;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          WW   = $clog2(WI + 1);
  localparam int          IW   = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          hit_pulse = 1'b0;
  logic          miss_pulse = 1'b0;
  logic [N-1:0]  active_onehot;
  logic          led_toggle;
  logic [WW-1:0] window_cycles;
  logic [7:0]    round_cnt;

  always #5 clk = ~clk;

  mole_spawner #(
    .N_MOLES(N), .WINDOW_INIT(WI), .WINDOW_MIN(WMIN), .WINDOW_STEP(WST),
    .GAP_CYCLES(GAP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .active_onehot(active_onehot), .led_toggle(led_toggle),
    .window_cycles(window_cycles), .round_cnt(round_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // post: bit1 = hit_pulse, bit0 = miss_pulse in the first dark cycle after the mole
  typedef struct {
    int hit_at;
    int miss_at;
    int post;
    int exp_len;
    int exp_tog;
    int exp_win;
  } round_t;

  typedef struct {
    int len;
    int tog;
  } exp_t;

  exp_t sb_q[$];
  round_t tbl [14];
  logic [7:0] exp_round = 8'd0;

  // Reference LFSR; lfsr_prev_m holds the value the DUT saw before the last edge.
  logic [15:0] lfsr_m, lfsr_prev_m;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_m      <= SEED;
      lfsr_prev_m <= SEED;
    end else begin
      lfsr_prev_m <= lfsr_m;
      lfsr_m      <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  logic [N-1:0] seen_mask = '0;

  initial begin
    int  mon_len = 0, mon_tog = 0, mon_dark = 0, last_idx = N - 1;
    bit  in_show = 0, gap_valid = 0, prev_tog = 0, tog_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_show   = 0;
        gap_valid = 0;
        prev_tog  = 0;
        last_idx  = N - 1;
      end else begin
        if (led_toggle) begin
          check("toggle_while_dark", 64'(active_onehot != '0), 64'd1);
          check("toggle_back_to_back", 64'(prev_tog), 64'd0);
        end
        if (active_onehot != '0) begin
          if (!in_show) begin
            int e, obs;
            e = int'(lfsr_prev_m[IW-1:0]);
            if (e >= N) e -= N;
            if (e == last_idx) e = (e + 1) % N;
            check("mole_select", 64'(active_onehot), 64'd1 << e);
            obs = -1;
            for (int i = 0; i < N; i++) if (active_onehot[i]) obs = i;
            check("mole_repeat", 64'(obs == last_idx), 64'd0);
            if (gap_valid) check("gap_length", 64'(mon_dark), 64'(GAP));
            if (obs >= 0) seen_mask[obs] = 1'b1;
            last_idx = obs;
            in_show  = 1;
            mon_len  = 0;
            mon_tog  = 0;
          end
          mon_len++;
          if (led_toggle) mon_tog++;
          tog_last = led_toggle;
        end else begin
          if (in_show) begin
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL scoreboard: mole episode len %0d seen, expected none", mon_len);
            end else begin
              exp_t x;
              x = sb_q.pop_front();
              check("window_length", 64'(mon_len), 64'(x.len));
              check("toggle_count", 64'(mon_tog), 64'(x.tog));
              check("toggle_on_last", 64'(tog_last), 64'(x.tog));
            end
            $display("round %0d: mole %0d lit %0d cycles, toggles %0d, window now %0d",
                     round_cnt, last_idx, mon_len, mon_tog, window_cycles);
            in_show   = 0;
            mon_dark  = 0;
            gap_valid = 1;
          end
          mon_dark++;
        end
        if (!enable) gap_valid = 0;
        prev_tog = led_toggle;
      end
    end
  end

  task automatic wait_light(output int n);
    n = 0;
    while (active_onehot == '0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (active_onehot == '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL light_timeout: no mole after %0d cycles, required one", n);
    end
  endtask

  task automatic run_round(input round_t r);
    int   n, c;
    exp_t x;
    wait_light(n);
    if (active_onehot == '0) return;
    exp_round++;
    check("round_cnt", 64'(round_cnt), 64'(exp_round));
    x.len = r.exp_len;
    x.tog = r.exp_tog;
    sb_q.push_back(x);
    c = 0;
    while (active_onehot != '0 && c < 100) begin
      hit_pulse  = (r.hit_at != 0 && c == r.hit_at - 1);
      miss_pulse = (r.miss_at != 0 && c == r.miss_at - 1);
      @(posedge clk);
      #1;
      c++;
    end
    hit_pulse  = 1'b0;
    miss_pulse = 1'b0;
    if (active_onehot != '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL window_timeout: mole still lit after %0d cycles, required dark", c);
    end
    hit_pulse  = (r.post & 2) != 0;
    miss_pulse = (r.post & 1) != 0;
    @(posedge clk);
    #1;
    hit_pulse  = 1'b0;
    miss_pulse = 1'b0;
    check("window_cycles", 64'(window_cycles), 64'(r.exp_win));
  endtask

  initial begin
    int     n, w;
    round_t r;
    //          hit miss post len tog win
    tbl = '{ '{0, 0, 1, 20, 1, 20},
             '{0, 0, 1, 20, 1, 20},
             '{0, 0, 1, 20, 1, 20},
             '{3, 0, 0,  3, 0, 16},
             '{3, 0, 0,  3, 0, 12},
             '{3, 0, 0,  3, 0,  8},
             '{3, 0, 0,  3, 0,  8},
             '{0, 0, 1,  8, 1, 12},
             '{0, 0, 2, 12, 1,  8},
             '{0, 0, 3,  8, 1,  8},
             '{0, 0, 1,  8, 1, 12},
             '{11, 0, 0, 11, 0, 8},
             '{0, 2, 0,  8, 1, 12},
             '{0, 0, 0, 12, 1, 12} };

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("pre_reset_lit", 64'(active_onehot != '0), 64'd1);
    check("pre_reset_round", 64'(round_cnt), 64'd1);

    // Reset asserted between edges must clear outputs immediately.
    @(negedge clk);
    #2;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    check("rst_active", 64'(active_onehot), 64'd0);
    check("rst_toggle", 64'(led_toggle), 64'd0);
    check("rst_window", 64'(window_cycles), 64'(WI));
    check("rst_round", 64'(round_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_round = 8'd0;
    @(posedge clk);
    #1;
    check("idle_dark", 64'(active_onehot), 64'd0);

    enable = 1'b1;
    wait_light(n);
    check("first_gap", 64'(n), 64'(GAP + 1));

    for (int i = 0; i < 14; i++) run_round(tbl[i]);

    w = 12;
    for (int k = 0; k < 250; k++) begin
      w = (w - WST < WMIN) ? WMIN : w - WST;
      r = '{1, 0, 0, 1, 0, w};
      run_round(r);
    end
    check("all_moles_seen", 64'(seen_mask), (64'd1 << N) - 64'd1);

    // Drop enable three cycles into a window, then bring the game back.
    begin
      exp_t x;
      wait_light(n);
      exp_round++;
      check("round_cnt", 64'(round_cnt), 64'(exp_round));
      x.len = 3;
      x.tog = 0;
      sb_q.push_back(x);
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("disable_clear", 64'(active_onehot), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("disable_toggle", 64'(led_toggle), 64'd0);
      check("disable_round", 64'(round_cnt), 64'(exp_round));
      check("disable_window", 64'(window_cycles), 64'(w));
      enable = 1'b1;
      wait_light(n);
      check("reenable_gap", 64'(n), 64'(GAP + 1));
      r = '{0, 0, 0, w, 1, w};
      run_round(r);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mole_spawner.md
# mole_spawner

Upstream stage of the mole detector in the whack-a-mole datapath. Chooses which mole lights next with a free-running LFSR, drives `active_onehot` for a bounded display window, and pulses `led_toggle` when that window expires. It consumes the detector's `hit_pulse`/`miss_pulse` to end a window early and to adapt the window length: hits shorten it, misses lengthen it.

## Interface
- `N_MOLES`, default 10: number of moles/LEDs; legal range 2..16.
- `WINDOW_INIT`, default 50_000_000: initial and maximum display window, in clk cycles.
- `WINDOW_MIN`, default 10_000_000: floor for the window; requires 2 ≤ `WINDOW_MIN` ≤ `WINDOW_INIT`.
- `WINDOW_STEP`, default 2_500_000: window decrement per hit and increment per miss.
- `GAP_CYCLES`, default 12_500_000: dark cycles between moles; requires ≥ 2.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `enable`  in  1: game running; level-sensitive.
- `hit_pulse`  in  1: one-cycle pulse from the detector on a correct hit.
- `miss_pulse`  in  1: one-cycle pulse from the detector on a miss.
- `active_onehot`  out  `N_MOLES`: currently lit mole; all-zero or exactly one bit set.
- `led_toggle`  out  1: one-cycle pulse in the last cycle of an unhit window.
- `window_cycles`  out  `WIN_W` = `$clog2(WINDOW_INIT+1)`: current window length.
- `round_cnt`  out  8: number of moles spawned; wraps 255→0.

## Operation
- **States**
  - IDLE: all LEDs off.
  - GAP: counting dark cycles.
  - SHOW: mole lit.
- **Transitions**
  - IDLE→GAP when `enable`=1.
  - GAP→SHOW when the gap counter expires.
  - SHOW→GAP on `hit_pulse`, or when the window counter expires.
  - Any state→IDLE when `enable`=0; this has the highest priority.
- **LFSR**
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every cycle in every state, including IDLE, so mole order depends on player timing.
  - Reset value is `LFSR_SEED`.
- **Mole selection** (at the GAP→SHOW edge)
  - `idx` = `lfsr[IW-1:0]`, with `IW` = `$clog2(N_MOLES)`.
  - If `idx` ≥ `N_MOLES`, subtract `N_MOLES`.
  - If `idx` equals the previous mole index, use (`idx`+1) mod `N_MOLES`. There are never two consecutive identical moles.
  - The previous-mole index resets to `N_MOLES-1`.
- **On entering SHOW**
  - `active_onehot` <= `1 << idx`.
  - The window counter loads `window_cycles`. Later changes to `window_cycles` do not affect the current window.
  - `round_cnt` increments.
- **Window adaptation**
  - Applied on every `hit_pulse` or `miss_pulse`, in any state except IDLE.
  - Hit: `window_cycles` = max(`window_cycles` − `WINDOW_STEP`, `WINDOW_MIN`).
  - Miss: `window_cycles` = min(`window_cycles` + `WINDOW_STEP`, `WINDOW_INIT`).
  - Compute with one guard bit and saturate; no wrap.
  - If both pulses arrive in the same cycle, the hit wins.
- **Hit in SHOW**
  - `active_onehot` clears at the same edge that samples `hit_pulse`.
  - Go to GAP; no `led_toggle` is issued, even if the window counter is at its last cycle.
- **Window expiry without a hit**
  - `led_toggle`=1 during the final SHOW cycle.
  - `active_onehot` clears, and the state goes to GAP, at the following edge.
- **`hit_pulse` arriving in GAP** (press landed on the expiry cycle): window adaptation only; no state change.
- **`enable` falling mid-operation**
  - Enter IDLE at the next edge with `active_onehot` cleared and counters cleared.
  - `window_cycles` and `round_cnt` hold.
  - The detector may report a disappeared-mole miss; this is accepted behaviour.
- **Reset** (async, any state)
  - State IDLE, `active_onehot`=0, `led_toggle`=0.
  - `window_cycles`=`WINDOW_INIT`, `round_cnt`=0.
  - LFSR=`LFSR_SEED`.

## Timing
- `enable` sampled high at edge E0: GAP for `GAP_CYCLES` cycles; `active_onehot` nonzero from edge E0+`GAP_CYCLES`.
- Unhit mole: `active_onehot` is nonzero for exactly `window_cycles` cycles. `led_toggle` coincides with the last of them. The next mole lights `GAP_CYCLES` cycles after the clear.
- Hit: `hit_pulse` sampled at edge H → `active_onehot`=0 from edge H. The detector is in IDLE from edge H and sees the LEDs dark.
- `led_toggle` is never high while `active_onehot`=0, and never high in two consecutive cycles.
- `GAP_CYCLES` ≥ 2 guarantees the detector has returned to IDLE before the next mole lights.
- All outputs are registered.

## Test plan
- **Reset and first mole.** Parameters `WINDOW_INIT`=20, `WINDOW_MIN`=8, `WINDOW_STEP`=4, `GAP_CYCLES`=5. Assert `rst` mid-cycle, then raise `enable` → all outputs at reset values; `active_onehot` one-hot 5 cycles after `enable`; `round_cnt`=1.
- **No hits.** Run 3 windows → each `active_onehot` high exactly 20 cycles; `led_toggle` on cycle 20 only. After each detector `miss_pulse`, `window_cycles` stays 20 (saturated).
- **Hits.** Issue `hit_pulse` 3 cycles into each SHOW for 4 rounds → LEDs clear at the sampling edge; no `led_toggle`; `window_cycles` goes 16, 12, 8, 8.
- **Hit on the expiry edge.** With `led_toggle` high, `hit_pulse` arrives the next cycle (in GAP) → no state disruption; `window_cycles` decrements once.
- **Mole selection.** Run 200 rounds → each value is one-hot with index < 10; no index repeats consecutively; every index appears.
- **Mid-window disable.** Drop `enable` during SHOW → `active_onehot`=0 next edge; no `led_toggle`; `round_cnt` and `window_cycles` hold. Re-enable → GAP of 5 cycles, then a new mole.
